// File: rtl/bram_stream_loader_if.sv
// bram_stream_loader_if: pixel stream in, word stream out, and the single
// bram port, bundled for the loader and its environment.
// master = loader side, slave = stream source/sink and bram side.
interface bram_stream_loader_if #(
  parameter int DWIDTH = 64,
  parameter int PWIDTH = 8,
  parameter int DDepth = 2048
);
  // Same address sizing as the bram itself: bits needed to hold DDepth-1.
  function automatic int clogb2(input int depth);
    int r;
    int d;
    r = 0;
    d = depth;
    while (d > 0) begin
      r++;
      d = d >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int AWIDTH = clogb2(DDepth - 1);

  logic              s_valid;
  logic              s_ready;
  logic [PWIDTH-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [DWIDTH-1:0] m_data;
  logic              m_last;
  logic [AWIDTH-1:0] bram_addr;
  logic              bram_ce;
  logic              bram_we;
  logic [DWIDTH-1:0] bram_din;
  logic [DWIDTH-1:0] bram_dout;

  modport master (
    input  s_valid, s_data, s_last, m_ready, bram_dout,
    output s_ready, m_valid, m_data, m_last, bram_addr, bram_ce, bram_we, bram_din
  );

  modport slave (
    output s_valid, s_data, s_last, m_ready, bram_dout,
    input  s_ready, m_valid, m_data, m_last, bram_addr, bram_ce, bram_we, bram_din
  );
endinterface

// File: rtl/bram_stream_loader.sv
// bram_stream_loader: packs a PWIDTH pixel stream into DWIDTH words, writes
// them to a single-port bram from address 0 (FILL/FLUSH), then reads them back
// as a valid/ready word stream through a 2-entry skid FIFO (DRAIN).
// The loader is the only master of the bram port, so reads and writes never
// collide.
// Optional feature macro: STALL_CNT_EN adds stall_cnt[31:0], the number of
// DRAIN cycles with m_valid & !m_ready (saturating, cleared by rst and start).
module bram_stream_loader #(
  parameter int DWIDTH = 64,
  parameter int DDepth = 2048,
  parameter int PWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  bram_stream_loader_if.master bus,
  output logic                 busy,
  output logic                 ovf
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);
  function automatic int clogb2(input int depth);
    int r;
    int d;
    r = 0;
    d = depth;
    while (d > 0) begin
      r++;
      d = d >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int AWIDTH = clogb2(DDepth - 1);
  localparam int LANES  = DWIDTH / PWIDTH;
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
  // Pointers carry one extra bit so a full bram (DDepth words) is countable.
  localparam logic [AWIDTH:0] LAST_ADDR = (AWIDTH + 1)'(DDepth - 1);
  localparam logic [LW-1:0]   LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, FILL, FLUSH, DRAIN} state_t;

  state_t            state, state_nxt;
  logic              wr_pend;     // a completed mid-frame word waits for its write cycle
  logic [LW-1:0]     lane;
  logic [DWIDTH-1:0] pack;        // lanes gathered so far for the current word
  logic [DWIDTH-1:0] din_q;       // last completed word, drives bram_din
  logic [DWIDTH-1:0] pix_word;
  logic [AWIDTH:0]   wr_ptr;      // next write address; word count once FILL ends
  logic [AWIDTH:0]   rd_ptr;
  logic              infl;        // a read was issued last cycle, dout valid now
  logic              infl_last;   // ...and it was the final word of the frame

  logic [DWIDTH-1:0] fifo_d [2];
  logic              fifo_l [2];
  logic              hd, tl;
  logic [1:0]        occ;

  logic              acc, word_done, close, pop, head_last, room;
  logic              s_ready_c, ce_c, we_c, wr_fire, rd_fire;
  logic [AWIDTH-1:0] addr_c;

  assign acc       = (state == FILL) && !wr_pend && bus.s_valid;
  assign word_done = (lane == LAST_LANE) || bus.s_last;
  // Word that ends the frame: either the producer said so or the bram is full.
  assign close     = word_done && (bus.s_last || (wr_ptr == LAST_ADDR));
  assign pix_word  = pack | (DWIDTH'(bus.s_data) << (PWIDTH * int'(lane)));
  assign head_last = fifo_l[hd];
  assign pop       = (occ != 2'd0) && bus.m_ready;
  // Count this cycle's pop as free space so m_ready=1 sustains a word per cycle.
  assign room      = (({1'b0, occ} + {2'b0, infl} - {2'b0, pop}) < 3'd2);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and bram port control.
  always_comb begin
    state_nxt = state;
    s_ready_c = 1'b0;
    ce_c      = 1'b0;
    we_c      = 1'b0;
    addr_c    = '0;
    wr_fire   = 1'b0;
    rd_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FILL;
      end
      FILL: begin
        s_ready_c = !wr_pend;
        addr_c    = wr_ptr[AWIDTH-1:0];
        if (wr_pend) begin
          ce_c    = 1'b1;
          we_c    = 1'b1;
          wr_fire = 1'b1;
        end
        if (acc && close) state_nxt = FLUSH;
      end
      FLUSH: begin
        // Single write cycle for the frame-closing word.
        ce_c      = 1'b1;
        we_c      = 1'b1;
        addr_c    = wr_ptr[AWIDTH-1:0];
        wr_fire   = 1'b1;
        state_nxt = DRAIN;
      end
      DRAIN: begin
        addr_c = rd_ptr[AWIDTH-1:0];
        if ((rd_ptr < wr_ptr) && room) begin
          ce_c    = 1'b1;
          rd_fire = 1'b1;
        end
        if (pop && head_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Packing, pointers, overflow flag and skid FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pend   <= 1'b0;
      lane      <= '0;
      pack      <= '0;
      din_q     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      infl      <= 1'b0;
      infl_last <= 1'b0;
      hd        <= 1'b0;
      tl        <= 1'b0;
      occ       <= 2'd0;
      ovf       <= 1'b0;
    end else begin
      if (state == IDLE && start) ovf <= 1'b0;
      if (acc) begin
        if (word_done) begin
          din_q   <= pix_word;
          pack    <= '0;
          lane    <= '0;
          wr_pend <= !close;
          if (close && !bus.s_last) ovf <= 1'b1;
        end else begin
          pack <= pix_word;
          lane <= lane + 1'b1;
        end
      end
      if (wr_fire) begin
        wr_ptr  <= wr_ptr + 1'b1;
        wr_pend <= 1'b0;
      end
      infl <= rd_fire;
      if (rd_fire) begin
        rd_ptr    <= rd_ptr + 1'b1;
        infl_last <= (rd_ptr == wr_ptr - 1'b1);
      end
      if (infl) tl <= ~tl;
      if (pop)  hd <= ~hd;
      occ <= occ + {1'b0, infl} - {1'b0, pop};
      if (pop && head_last) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
    end
  end

  // Skid FIFO storage: capture read data the cycle after the read.
  always_ff @(posedge clk) begin
    if (infl) begin
      fifo_d[tl] <= bus.bram_dout;
      fifo_l[tl] <= infl_last;
    end
  end

`ifdef STALL_CNT_EN
  // Saturating count of back-pressured output cycles during DRAIN.
  always_ff @(posedge clk) begin
    if (rst)                                      stall_cnt <= '0;
    else if (state == IDLE && start)              stall_cnt <= '0;
    else if (state == DRAIN && (occ != 2'd0) && !bus.m_ready && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

  assign bus.s_ready   = s_ready_c;
  assign bus.bram_ce   = ce_c;
  assign bus.bram_we   = we_c;
  assign bus.bram_addr = addr_c;
  assign bus.bram_din  = din_q;
  assign bus.m_valid   = (occ != 2'd0);
  assign bus.m_data    = fifo_d[hd];
  assign bus.m_last    = (occ != 2'd0) && head_last;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_bram_stream_loader.sv
// tb_bram_stream_loader: two loaders (deep bram and a 4-word bram) behind a
// shared stimulus mux, each with a behavioural single-port bram. Random frames
// are checked against a reference model that packs pixels with plain arithmetic.
module tb_bram_stream_loader;
  localparam int DW = 64, PW = 8, D0 = 2048, D1 = 4, LANES = DW / PW;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0, sel = 1'b0;
  logic [7:0] s_data = 8'h0;
  logic       busy0, busy1, ovf0, ovf1;

  bram_stream_loader_if #(.DWIDTH(DW), .PWIDTH(PW), .DDepth(D0)) b0 ();
  bram_stream_loader_if #(.DWIDTH(DW), .PWIDTH(PW), .DDepth(D1)) b1 ();

`ifdef STALL_CNT_EN
  logic [31:0] sc0, sc1, sc_m;
  assign sc_m = sel ? sc1 : sc0;
`endif

  bram_stream_loader #(.DWIDTH(DW), .DDepth(D0), .PWIDTH(PW)) u0 (
    .clk(clk), .rst(rst), .start(start & ~sel), .bus(b0), .busy(busy0), .ovf(ovf0)
`ifdef STALL_CNT_EN
    , .stall_cnt(sc0)
`endif
  );
  bram_stream_loader #(.DWIDTH(DW), .DDepth(D1), .PWIDTH(PW)) u1 (
    .clk(clk), .rst(rst), .start(start & sel), .bus(b1), .busy(busy1), .ovf(ovf1)
`ifdef STALL_CNT_EN
    , .stall_cnt(sc1)
`endif
  );

  assign b0.s_valid = s_valid & ~sel;
  assign b1.s_valid = s_valid & sel;
  assign b0.s_data  = s_data;
  assign b1.s_data  = s_data;
  assign b0.s_last  = s_last;
  assign b1.s_last  = s_last;
  assign b0.m_ready = m_ready & ~sel;
  assign b1.m_ready = m_ready & sel;

  logic [63:0] mem0 [D0];
  logic [63:0] mem1 [D1];
  always @(posedge clk) begin
    if (b0.bram_ce) begin
      if (b0.bram_we) mem0[b0.bram_addr] <= b0.bram_din;
      else            b0.bram_dout <= mem0[b0.bram_addr];
    end
  end
  always @(posedge clk) begin
    if (b1.bram_ce) begin
      if (b1.bram_we) mem1[b1.bram_addr] <= b1.bram_din;
      else            b1.bram_dout <= mem1[b1.bram_addr];
    end
  end

  logic        s_ready_m, m_valid_m, m_last_m, ce_m, we_m, busy_m, ovf_m;
  logic [63:0] m_data_m, din_m;
  int          addr_m;
  assign s_ready_m = sel ? b1.s_ready : b0.s_ready;
  assign m_valid_m = sel ? b1.m_valid : b0.m_valid;
  assign m_last_m  = sel ? b1.m_last  : b0.m_last;
  assign m_data_m  = sel ? b1.m_data  : b0.m_data;
  assign ce_m      = sel ? b1.bram_ce : b0.bram_ce;
  assign we_m      = sel ? b1.bram_we : b0.bram_we;
  assign din_m     = sel ? b1.bram_din : b0.bram_din;
  assign addr_m    = sel ? int'(b1.bram_addr) : int'(b0.bram_addr);
  assign busy_m    = sel ? busy1 : busy0;
  assign ovf_m     = sel ? ovf1 : ovf0;

  int n_chk = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  pix [$];
  logic [63:0] exp_w [$], rx_w [$], wr_d [$];
  logic        rx_l [$];
  int          wr_a [$];
  int          first_mv, last_hs, last_wr, stall_exp, unstable, sready_bad, acc_got;
  bit          drain_seen, timeout;

  always @(negedge clk) begin
    if (ce_m && we_m) begin
      wr_a.push_back(addr_m);
      wr_d.push_back(din_m);
      last_wr = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int n, input bit use_last, input bit noise);
    int i, g;
    i = 0;
    g = 0;
    while (i < n && !drain_seen) begin
      @(negedge clk);
      g++;
      if (g > 4000) begin timeout = 1'b1; break; end
      if (noise) start = ($urandom_range(0, 7) == 0);
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = pix[i];
      s_last  = use_last && (i == n - 1);
      if (s_valid && s_ready_m) i++;
    end
    acc_got = i;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic consume(input int rmode, input bit noise);
    bit          got_last, prev_stall;
    logic [63:0] prev_data;
    int          g;
    got_last   = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    g          = 0;
    while (!got_last && !(rmode == 3 && rx_w.size() == 1)) begin
      @(negedge clk);
      g++;
      if (g > 4000) begin timeout = 1'b1; break; end
      if (noise) start = ($urandom_range(0, 7) == 0);
      if (prev_stall && (!m_valid_m || m_data_m !== prev_data)) unstable++;
      if (drain_seen && s_ready_m) sready_bad++;
      if (m_valid_m && !drain_seen) begin drain_seen = 1'b1; first_mv = cyc; end
      case (rmode)
        1:       m_ready = cyc[0];
        2:       m_ready = ($urandom_range(0, 1) == 1);
        default: m_ready = 1'b1;
      endcase
      if (m_valid_m && m_ready) begin
        rx_w.push_back(m_data_m);
        rx_l.push_back(m_last_m);
        last_hs = cyc;
        if (m_last_m) got_last = 1'b1;
      end
      if (m_valid_m && !m_ready) stall_exp++;
      prev_stall = m_valid_m && !m_ready;
      prev_data  = m_data_m;
    end
  endtask

  // Reference model: pixels accepted up to bram capacity, LANES per word, first pixel LSB.
  task automatic run_frame(input logic s, input bit use_last, input int rmode, input bit noise);
    int  n, cap, acc_exp, nw, nl, li;
    bit  exp_ovf;
    n       = pix.size();
    cap     = (s ? D1 : D0) * LANES;
    acc_exp = (n > cap) ? cap : n;
    exp_ovf = (n > cap) || (!use_last && n == cap);
    nw      = (acc_exp + LANES - 1) / LANES;
    exp_w.delete();
    for (int j = 0; j < nw; j++) begin
      logic [63:0] w;
      w = '0;
      for (int k = 0; k < LANES; k++)
        if (j * LANES + k < acc_exp) w[k*8 +: 8] = pix[j*LANES + k];
      exp_w.push_back(w);
    end
    sel = s;
    rx_w.delete(); rx_l.delete(); wr_a.delete(); wr_d.delete();
    drain_seen = 1'b0; timeout = 1'b0;
    stall_exp = 0; unstable = 0; sready_bad = 0; first_mv = 0; last_hs = 0; last_wr = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    fork
      drive(n, use_last, noise);
      consume(rmode, noise);
    join
    if (rmode == 3) begin
      m_ready = 1'b0;
      start   = 1'b0;
      return;
    end
    @(negedge clk);
    m_ready = 1'b0;
    start   = 1'b0;
    chk("timeout", 64'(timeout), 64'd0);
    chk("busy_after", 64'(busy_m), 64'd0);
    chk("accepted", 64'(acc_got), 64'(acc_exp));
    chk("ovf", 64'(ovf_m), 64'(exp_ovf));
    chk("rx_count", 64'(rx_w.size()), 64'(nw));
    chk("wr_count", 64'(wr_d.size()), 64'(nw));
    for (int j = 0; j < nw && j < rx_w.size(); j++)
      chk($sformatf("rx_word%0d", j), rx_w[j], exp_w[j]);
    for (int j = 0; j < nw && j < wr_d.size(); j++) begin
      chk($sformatf("wr_addr%0d", j), 64'(wr_a[j]), 64'(j));
      chk($sformatf("wr_data%0d", j), wr_d[j], exp_w[j]);
    end
    nl = 0;
    li = -1;
    foreach (rx_l[j]) if (rx_l[j]) begin nl++; li = j; end
    chk("mlast_cnt", 64'(nl), 64'd1);
    chk("mlast_pos", 64'(li), 64'(nw - 1));
    chk("stable_stall", 64'(unstable), 64'd0);
    chk("sready_drain", 64'(sready_bad), 64'd0);
    chk("latency", 64'(first_mv - last_wr), 64'd3);
    if (rmode == 0) chk("back_to_back", 64'(last_hs - first_mv), 64'(nw - 1));
`ifdef STALL_CNT_EN
    chk("stall_cnt", 64'(sc_m), 64'(stall_exp));
`endif
  endtask

  task automatic fill_seq(input int n);
    pix.delete();
    for (int i = 1; i <= n; i++) pix.push_back(8'(i));
  endtask

  task automatic fill_rand(input int n);
    pix.delete();
    for (int i = 0; i < n; i++) pix.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    sel = 1'b0; #1;
    chk("rst_busy0", 64'(busy_m), 64'd0);
    chk("rst_mvalid0", 64'(m_valid_m), 64'd0);
    chk("rst_mlast0", 64'(m_last_m), 64'd0);
    chk("rst_sready0", 64'(s_ready_m), 64'd0);
    chk("rst_ce0", 64'(ce_m), 64'd0);
    chk("rst_ovf0", 64'(ovf_m), 64'd0);
    sel = 1'b1; #1;
    chk("rst_busy1", 64'(busy_m), 64'd0);
    chk("rst_ce1", 64'(ce_m), 64'd0);
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    fill_seq(16);
    run_frame(1'b0, 1'b1, 0, 1'b0);
    if (rx_w.size() >= 2) begin
      chk("dir16_rx0", rx_w[0], 64'h0807060504030201);
      chk("dir16_rx1", rx_w[1], 64'h100F0E0D0C0B0A09);
    end

    fill_seq(11);
    run_frame(1'b0, 1'b1, 0, 1'b0);
    if (wr_d.size() >= 2) chk("dir11_addr1", wr_d[1], 64'h00000000000B0A09);

    fill_rand(24);
    run_frame(1'b0, 1'b1, 1, 1'b1);

    for (int t = 0; t < 6; t++) begin
      fill_rand($urandom_range(1, 60));
      run_frame(1'b0, 1'b1, 2, 1'b1);
    end

    fill_seq(40);
    run_frame(1'b1, 1'b0, 0, 1'b0);

    fill_rand(32);
    run_frame(1'b1, 1'b1, 2, 1'b1);

    fill_rand(40);
    run_frame(1'b1, 1'b0, 3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_mvalid", 64'(m_valid_m), 64'd0);
    chk("rst_mid_busy", 64'(busy_m), 64'd0);
    chk("rst_mid_ovf", 64'(ovf_m), 64'd0);
    rst = 1'b0;

    fill_rand(12);
    run_frame(1'b1, 1'b1, 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
